// File: rtl/opacc_tile_if.sv
// Command, load and store channels between the MPU command decoder / vector
// register file (master) and the outer-product accumulator tile (slave).
interface opacc_tile_if #(
   parameter int NREGS = 2,
   parameter int ML    = 4,
   parameter int VL    = 4,
   parameter int XLEN  = 64
);
   localparam int RA = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [1:0]           cmd_op;
   logic [RA-1:0]        cmd_reg;
   logic                 cmd_sub;
   logic [ML*XLEN-1:0]   cmd_a;
   logic [VL*XLEN-1:0]   cmd_b;

   logic                 ld_valid;
   logic                 ld_ready;
   logic [VL*XLEN-1:0]   ld_data;

   logic                 st_valid;
   logic                 st_ready;
   logic [VL*XLEN-1:0]   st_data;
   logic                 st_last;

   logic                 busy;

   modport master (
      output cmd_valid, cmd_op, cmd_reg, cmd_sub, cmd_a, cmd_b,
      output ld_valid, ld_data, st_ready,
      input  cmd_ready, ld_ready, st_valid, st_data, st_last, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_reg, cmd_sub, cmd_a, cmd_b,
      input  ld_valid, ld_data, st_ready,
      output cmd_ready, ld_ready, st_valid, st_data, st_last, busy
   );
endinterface

// File: rtl/opacc_tile.sv
// Multi-bank outer-product accumulator tile: per-cycle MAC into NREGS banks of
// ML x VL accumulators, plus bank clear and row-serial load/store.
module opacc_tile #(
   parameter int NREGS = 2,
   parameter int ML    = 4,
   parameter int VL    = 4,
   parameter int XLEN  = 64
) (
   input  logic         clk,
   input  logic         reset,
   opacc_tile_if.slave  bus,
   output logic [1:0]   dbg_state_o
);
   localparam int RA = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int RW = (ML > 1) ? $clog2(ML) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_STORE = 2'd2;

   localparam logic [1:0] OP_ZERO  = 2'd0;
   localparam logic [1:0] OP_MAC   = 2'd1;
   localparam logic [1:0] OP_LOAD  = 2'd2;
   localparam logic [1:0] OP_STORE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [RA-1:0] bank_q, bank_d;
   logic [NREGS-1:0][ML-1:0][VL-1:0][XLEN-1:0] acc_q, acc_d;
   logic [ML-1:0][VL-1:0][XLEN-1:0]            prod;
   logic [VL*XLEN-1:0]                         st_row;
   logic                                       row_last;

   // Every channel is a valid/ready pair: a transfer happens on the rising edge
   // where both are high. cmd_ready is high only in IDLE, ld_ready only in LOAD,
   // st_valid only in STORE; st_data/st_valid hold steady while st_ready is low.
   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.ld_ready  = (state_q == S_LOAD);
   assign bus.st_valid  = (state_q == S_STORE);
   assign bus.busy      = (state_q != S_IDLE);
   assign row_last      = (row_q == RW'(ML - 1));
   assign bus.st_last   = (state_q == S_STORE) && row_last;
   assign bus.st_data   = st_row;
   assign dbg_state_o   = state_q;

   always_comb begin
      for (int i = 0; i < ML; i++) begin
         for (int j = 0; j < VL; j++) begin
            prod[i][j] = bus.cmd_a[i*XLEN +: XLEN] * bus.cmd_b[j*XLEN +: XLEN];
         end
      end
   end

   // Out-of-range banks match no entry, so stores of them read back zeros.
   always_comb begin
      st_row = '0;
      if (state_q == S_STORE) begin
         for (int k = 0; k < NREGS; k++) begin
            if (bank_q == RA'(k)) st_row = acc_q[k][row_q];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      bank_d  = bank_q;
      acc_d   = acc_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  OP_ZERO: begin
                     for (int k = 0; k < NREGS; k++) begin
                        if (bus.cmd_reg == RA'(k)) acc_d[k] = '0;
                     end
                  end
                  OP_MAC: begin
                     for (int k = 0; k < NREGS; k++) begin
                        if (bus.cmd_reg == RA'(k)) begin
                           for (int i = 0; i < ML; i++) begin
                              for (int j = 0; j < VL; j++) begin
                                 acc_d[k][i][j] = bus.cmd_sub ? acc_q[k][i][j] - prod[i][j]
                                                              : acc_q[k][i][j] + prod[i][j];
                              end
                           end
                        end
                     end
                  end
                  OP_LOAD: begin
                     bank_d  = bus.cmd_reg;
                     row_d   = '0;
                     state_d = S_LOAD;
                  end
                  default: begin
                     bank_d  = bus.cmd_reg;
                     row_d   = '0;
                     state_d = S_STORE;
                  end
               endcase
            end
         end
         S_LOAD: begin
            if (bus.ld_valid) begin
               for (int k = 0; k < NREGS; k++) begin
                  if (bank_q == RA'(k)) acc_d[k][row_q] = bus.ld_data;
               end
               row_d = row_q + RW'(1);
               if (row_last) begin
                  row_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         S_STORE: begin
            if (bus.st_ready) begin
               row_d = row_q + RW'(1);
               if (row_last) begin
                  row_d   = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         bank_q  <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         bank_q  <= bank_d;
         acc_q   <= acc_d;
      end
   end
endmodule
